// File: rtl/mem_arbiter_if.sv
// Bus bundle between the MMIX fetch/load-store requesters, the memory arbiter
// and the memory controller. The arbiter takes the slave view; the environment takes master.
interface mem_arbiter_if;
    logic        f_read;
    logic [63:0] f_address;
    logic [1:0]  f_datasize;
    logic [63:0] f_readdata;
    logic        f_done;

    logic        d_read;
    logic        d_write;
    logic [63:0] d_address;
    logic [1:0]  d_datasize;
    logic [63:0] d_writedata;
    logic [63:0] d_readdata;
    logic        d_done;

    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_writedata;
    logic [63:0] mem_readdata;
    logic        mem_done;

    modport slave (
        input  f_read, f_address, f_datasize,
        output f_readdata, f_done,
        input  d_read, d_write, d_address, d_datasize, d_writedata,
        output d_readdata, d_done,
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done
    );

    modport master (
        output f_read, f_address, f_datasize,
        input  f_readdata, f_done,
        output d_read, d_write, d_address, d_datasize, d_writedata,
        input  d_readdata, d_done,
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the fetch and load/store requesters,
// alternating on ties and returning a registered one-cycle done pulse to the owner.
module mem_arbiter (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, WAIT} state_t;
    typedef enum logic {FETCH, DATA} port_t;

    state_t      state, state_nx;
    port_t       owner, last_grant;
    logic        f_req, d_req, any_req, grant_f, owner_req;

    logic [63:0] address_q, writedata_q, f_readdata_q, d_readdata_q;
    logic [1:0]  datasize_q;
    logic        read_q, write_q, f_done_q, d_done_q;

    always_comb begin
        f_req     = bus.f_read;
        d_req     = bus.d_read | bus.d_write;
        any_req   = f_req | d_req;
        // On a tie the port that did not win last time gets the bus.
        grant_f   = f_req & (~d_req | (last_grant == DATA));
        owner_req = (owner == FETCH) ? f_req : d_req;

        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = BUSY;
            BUSY:    if (bus.mem_done) state_nx = DONE;
            DONE:    state_nx = WAIT;
            WAIT:    if (!owner_req) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address_q    <= '0;
            datasize_q   <= '0;
            writedata_q  <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            f_readdata_q <= '0;
            d_readdata_q <= '0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            owner        <= FETCH;
            last_grant   <= DATA;
        end else begin
            f_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        if (grant_f) begin
                            address_q  <= bus.f_address;
                            datasize_q <= bus.f_datasize;
                            read_q     <= 1'b1;
                            owner      <= FETCH;
                            last_grant <= FETCH;
                        end else begin
                            address_q   <= bus.d_address;
                            datasize_q  <= bus.d_datasize;
                            writedata_q <= bus.d_writedata;
                            // read+write together is resolved as a write
                            read_q      <= ~bus.d_write;
                            write_q     <= bus.d_write;
                            owner       <= DATA;
                            last_grant  <= DATA;
                        end
                    end
                end
                BUSY: begin
                    if (bus.mem_done) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (owner == FETCH) begin
                            f_readdata_q <= bus.mem_readdata;
                            f_done_q     <= 1'b1;
                        end else begin
                            d_readdata_q <= bus.mem_readdata;
                            d_done_q     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_address   = address_q;
    assign bus.mem_datasize  = datasize_q;
    assign bus.mem_writedata = writedata_q;
    assign bus.mem_read      = read_q;
    assign bus.mem_write     = write_q;
    assign bus.f_readdata    = f_readdata_q;
    assign bus.f_done        = f_done_q;
    assign bus.d_readdata    = d_readdata_q;
    assign bus.d_done        = d_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench: two level-held requesters and a random-latency memory, checked
// cycle by cycle against a transaction-level schedule of grants, strobes and dones.
module tb_mem_arbiter;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();
  mem_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  // reference model: one outstanding transaction described by its cycle numbers
  bit          t_act = 0, t_own = 0, t_wr = 0, lastg = 1;
  logic [63:0] t_addr = '0, t_wdata = '0;
  logic [1:0]  t_size = '0;
  int          t_start = 0, t_lat = 0, t_dcyc = -1, free_cyc = 0;
  logic [63:0] e_frd = '0, e_drd = '0;
  // requester agents
  int          f_drop = -1, f_ok = 0, d_drop = -1, d_ok = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mem_read"},   64'(bus.mem_read),  64'd0);
    chk({pfx, "_mem_write"},  64'(bus.mem_write), 64'd0);
    chk({pfx, "_f_done"},     64'(bus.f_done),    64'd0);
    chk({pfx, "_d_done"},     64'(bus.d_done),    64'd0);
    chk({pfx, "_f_readdata"}, bus.f_readdata,     64'd0);
    chk({pfx, "_d_readdata"}, bus.d_readdata,     64'd0);
  endtask

  initial begin
    bit e_stb, e_done, dq, did_rst;
    int h, k;
    did_rst = 0;
    bus.f_read = 0; bus.f_address = '0; bus.f_datasize = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_datasize = '0;
    bus.d_writedata = '0; bus.mem_readdata = '0; bus.mem_done = 0;

    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    chk("rst_mem_address", bus.mem_address, 64'd0);
    chk("rst_mem_datasize", 64'(bus.mem_datasize), 64'd0);
    chk("rst_mem_writedata", bus.mem_writedata, 64'd0);
    reset_n = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc > 0) @(negedge clk);

      e_stb  = t_act && cyc >= t_start && (t_dcyc < 0 || cyc <= t_dcyc);
      e_done = t_act && t_dcyc >= 0 && cyc == t_dcyc + 1;

      chk("mem_read",  64'(bus.mem_read),  64'(e_stb && !t_wr));
      chk("mem_write", 64'(bus.mem_write), 64'(e_stb && t_wr));
      chk("f_done",    64'(bus.f_done),    64'(e_done && !t_own));
      chk("d_done",    64'(bus.d_done),    64'(e_done && t_own));
      chk("f_readdata", bus.f_readdata, e_frd);
      chk("d_readdata", bus.d_readdata, e_drd);
      if (e_stb) begin
        chk("mem_address",  bus.mem_address, t_addr);
        chk("mem_datasize", 64'(bus.mem_datasize), 64'(t_size));
        if (t_wr) chk("mem_writedata", bus.mem_writedata, t_wdata);
      end

      // owner saw done: it drops its request after h extra cycles
      if (e_done) begin
        h = $urandom_range(0, 2);
        free_cyc = (cyc + h + 1 > t_dcyc + 3) ? cyc + h + 1 : t_dcyc + 3;
        if (t_own) begin d_drop = cyc + h; d_ok = free_cyc + $urandom_range(0, 3); end
        else       begin f_drop = cyc + h; f_ok = free_cyc + $urandom_range(0, 3); end
        t_act = 0;
      end

      if (!did_rst && cyc >= 600 && e_stb && !t_wr) begin
        did_rst = 1;
        #1 reset_n = 1'b0;
        bus.mem_done = 0;
        #1 chk_all_zero("arst");
        t_act = 0; lastg = 1; e_frd = '0; e_drd = '0; e_stb = 0;
        repeat (2) @(negedge clk);
        cyc += 2;
        reset_n = 1'b1;
        free_cyc = cyc;
      end

      // fetch agent
      if (bus.f_read && f_drop >= 0 && cyc >= f_drop) begin
        bus.f_read = 0; f_drop = -1;
      end else if (!bus.f_read && f_drop < 0 && cyc >= f_ok &&
                   (cyc == 0 || $urandom_range(0, 2) == 0)) begin
        bus.f_read = 1;
        bus.f_address = {$urandom, $urandom};
        bus.f_datasize = 2'($urandom_range(0, 3));
      end
      // data agent; k==6 drives the illegal read+write combination
      dq = bus.d_read || bus.d_write;
      if (dq && d_drop >= 0 && cyc >= d_drop) begin
        bus.d_read = 0; bus.d_write = 0; d_drop = -1;
      end else if (!dq && d_drop < 0 && cyc >= d_ok &&
                   (cyc == 0 || $urandom_range(0, 2) == 0)) begin
        k = (cyc == 0) ? 0 : $urandom_range(0, 6);
        bus.d_read  = (k <= 2) || (k == 6);
        bus.d_write = (k >= 3);
        bus.d_address = {$urandom, $urandom};
        bus.d_datasize = 2'($urandom_range(0, 3));
        bus.d_writedata = {$urandom, $urandom};
      end
      dq = bus.d_read || bus.d_write;

      // arbitration of the levels the next edge will sample
      if (!t_act && cyc >= free_cyc && (bus.f_read || dq)) begin
        t_own   = (bus.f_read && dq) ? !lastg : dq;
        lastg   = t_own;
        t_act   = 1;
        t_start = cyc + 1;
        t_dcyc  = -1;
        t_lat   = $urandom_range(0, 3);
        t_wr    = t_own && bus.d_write;
        t_addr  = t_own ? bus.d_address : bus.f_address;
        t_size  = t_own ? bus.d_datasize : bus.f_datasize;
        t_wdata = bus.d_writedata;
      end

      // memory: completes after t_lat strobe cycles, stray dones while not busy
      bus.mem_readdata = {$urandom, $urandom};
      if (t_act && t_dcyc < 0 && cyc == t_start + t_lat) begin
        bus.mem_done = 1;
        t_dcyc = cyc;
        if (t_own) e_drd = bus.mem_readdata;
        else       e_frd = bus.mem_readdata;
      end else begin
        bus.mem_done = !e_stb && ($urandom_range(0, 7) == 0);
      end
    end

    chk("mid_op_reset_hit", 64'(did_rst), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single external memory port between the instruction fetch port and the load/store (data) port of the MMIX core. Each requester uses the level-held request / `done` handshake already used by the fetch path. The arbiter registers the winning request onto the memory port and steers `mem_done`/`mem_readdata` back to the owner as a one-cycle registered pulse. It sits between the core's fetch and load/store units and the memory controller.

## Interface
- Parameters: none.
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `f_read`  in  1  fetch read request, level-held until `f_done` seen
- `f_address`  in  64  fetch address
- `f_datasize`  in  2  fetch size (0 byte, 1 wyde, 2 tetra, 3 octa)
- `f_readdata`  out  64  fetch read data, valid while `f_done`=1
- `f_done`  out  1  fetch completion pulse
- `d_read`  in  1  data read request, level-held
- `d_write`  in  1  data write request, level-held
- `d_address`  in  64  data address
- `d_datasize`  in  2  data size
- `d_writedata`  in  64  data write data
- `d_readdata`  out  64  data read data, valid while `d_done`=1
- `d_done`  out  1  data completion pulse
- `mem_address`  out  64  memory address
- `mem_datasize`  out  2  memory access size
- `mem_read`  out  1  memory read strobe, held until `mem_done`
- `mem_write`  out  1  memory write strobe, held until `mem_done`
- `mem_writedata`  out  64  memory write data
- `mem_readdata`  in  64  memory read data, valid with `mem_done`
- `mem_done`  in  1  memory completion, one cycle

## Operation
- Reset values: all outputs 0; state IDLE; `last_grant` = DATA.
- States are IDLE, BUSY, DONE and WAIT.
- IDLE:
  - Fetch request = `f_read`. Data request = `d_read | d_write`.
  - One requester active: grant it.
  - Both active: grant the one not equal to `last_grant`. After reset, fetch wins the first tie.
  - On grant: latch address, size and writedata (data port) into the `mem_*` registers. Assert `mem_read` or `mem_write` from the next cycle. Set owner and `last_grant`. Go to BUSY.
  - `d_read` and `d_write` both high is illegal. The arbiter treats it as a write.
- BUSY:
  - `mem_*` outputs are held stable. Requester inputs are ignored.
  - On `mem_done`: clear `mem_read`/`mem_write`. Capture `mem_readdata` into the owner's readdata register. Go to DONE.
- DONE:
  - Owner's `*_done` = 1 for exactly this cycle. The other port's `*_done` stays 0.
  - Go to WAIT.
- WAIT:
  - Stay while the owner's request is still high.
  - When the owner's request is low, go to IDLE.
- `*_readdata` holds its last captured value outside DONE. On a write, it is updated with the (don't-care) `mem_readdata`.
- A non-owner request that rises during BUSY/DONE/WAIT is held pending. It is arbitrated in IDLE.
- The arbiter performs no address modification. Callers supply physical addresses.
- Reset asserted mid-transaction:
  - All strobes and dones drop immediately and the state returns to IDLE.
  - No `*_done` is issued for the aborted access.

## Timing
- Request high in IDLE cycle C → `mem_read`/`mem_write` high in cycle C+1.
- `mem_done` in cycle D → owner `*_done` = 1 and `*_readdata` valid in cycle D+1.
- Fetch-unit-style requester drops its request at the edge ending D+1:
  - WAIT in D+2.
  - IDLE in D+3.
  - Next grant's strobe in D+4.
- `mem_done` arriving in the same cycle the strobe first rises (zero-wait memory) is legal. BUSY exits on the first cycle it sees `mem_done`=1.
- `mem_done` outside BUSY is ignored.
- Minimum back-to-back spacing between memory strobes is 3 idle cycles. Memory address/size/data never change while a strobe is high.

## Test plan
- Single fetch: `f_read`=1, `f_address`=0x8000_0000_0000_0100, size 2; memory returns 0xF000_0000 after 3 cycles → `mem_read` 1 cycle after request; `f_done` for 1 cycle with `f_readdata`[31:0]=0xF000_0000; `d_done` stays 0.
- Data write: `d_write`=1, address 0x8000_0000_0000_2000, data 0x0123_4567_89AB_CDEF, size 3 → `mem_write`=1 with identical address/data/size held until `mem_done`; `d_done` pulses once.
- Simultaneous requests after reset: `f_read` and `d_read` rise together, both held → fetch served first, then data; repeat both → alternation F,D,F,D over 4 transactions.
- Zero-wait memory: `mem_done` tied high on the strobe's first cycle → exactly one `f_done` pulse, strobe high exactly 1 cycle, no duplicate access.
- Pending request during service: `d_read` rises while a fetch is in BUSY → no change on `mem_*` until the fetch completes; data strobe 3 cycles after `f_read` falls.
- Reset mid-op: assert `reset_n`=0 while `mem_read`=1 → `mem_read`, `f_done` and `d_done` go 0 asynchronously. After release with `f_read` held, a fresh fetch strobe occurs.
